// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4-channel scan sequencer: FSM encoding and channel constants.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

  localparam int         NUM_CH  = 4;
  localparam logic [1:0] LAST_CH = 2'd3;

endpackage

// File: rtl/mux4_scan_sequencer_if.sv
// Bundle between the scan sequencer and its surroundings (the 4:1 mux and the requester).
interface mux4_scan_sequencer_if;
  import mux_scan_pkg::*;

  // start is a level request taken only while idle; done is a one-cycle pulse
  // that coincides with the new sample value. There is no back-pressure.
  logic              start;
  logic              mux_out;
  logic [1:0]        select;
  logic              enable;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] sample;
  scan_state_e       state;

  modport master (
    input  start, mux_out,
    output select, enable, busy, done, sample, state
  );

  modport slave (
    output start, mux_out,
    input  select, enable, busy, done, sample, state
  );

endinterface

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter that times the settle interval of each mux channel.
module scan_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Walks a 4:1 mux through channels 0..3, settles DWELL cycles each, samples and publishes a snapshot.
// Define SCAN_CONTINUOUS_EN to chain scans back-to-back while start stays high.
module mux4_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mux4_scan_sequencer_if.master  bus
);

  if ((DWELL < 1) || (DWELL > ((2 ** CNT_W) - 1))) begin : g_dwell_check
    $error("mux4_scan_sequencer: DWELL=%0d outside 1..2**CNT_W-1", DWELL);
  end

  scan_state_e       state_q, state_d;
  logic [1:0]        select_q, select_d;
  logic              enable_q, enable_d;
  logic              busy_q, done_q;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] sample_q, sample_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  scan_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(DWELL - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    enable_d = 1'b0;

    case (state_q)
      IDLE: begin
        select_d = 2'd0;
        if (bus.start) begin
          state_d  = SETTLE;
          cnt_load = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        shadow_d[select_q] = bus.mux_out;
        if (select_q == LAST_CH) begin
          // Publish on entry to DONE so done and the new sample appear together.
          state_d  = DONE;
          sample_d = shadow_d;
        end else begin
          state_d  = SETTLE;
          select_d = select_q + 2'd1;
          cnt_load = 1'b1;
        end
      end
      DONE: begin
        select_d = 2'd0;
`ifdef SCAN_CONTINUOUS_EN
        if (bus.start) begin
          state_d  = SETTLE;
          cnt_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef SCAN_CONTINUOUS_EN
    // Keep the mux enabled through DONE when another scan is about to follow.
    enable_d = (state_d == SETTLE) || (state_d == SAMPLE) || ((state_d == DONE) && bus.start);
`else
    enable_d = (state_d == SETTLE) || (state_d == SAMPLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      select_q <= 2'd0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      enable_q <= enable_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      shadow_q <= shadow_d;
      sample_q <= sample_d;
    end
  end

  assign bus.select = select_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sample = sample_q;
  assign bus.state  = state_q;

endmodule

// File: doc/mux4_scan_sequencer.md
Name: mux4_scan_sequencer

Overview:
- Upstream/downstream companion to the 4:1 mux (inputs a..d, 2-bit select, enable, 1-bit out).
- Drives the mux `select` and `enable`, and lets each channel settle for DWELL cycles.
- Samples the mux output once per channel and assembles a 4-bit snapshot.
- On start, scans channels 0..3 once, then publishes the snapshot with a one-cycle done pulse.

Parameters:
- DWELL, 2, settle cycles per channel before sampling; legal range 1..(2**CNT_W - 1).
- CNT_W, 8, dwell counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one scan; sampled only in IDLE.
- mux_out  input  1  `out` of the 4:1 mux.
- select  output  2  to mux `select`; select[0] drives the first-level muxes, select[1] the second level.
- enable  output  1  to mux `enable`; high only while scanning.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when `sample` is updated.
- sample  output  4  snapshot; bit i = mux_out captured with select==i (bit0=in_a ... bit3=in_d).

Behaviour:
- Reset (synchronous, active-high) overrides everything, including mid-scan:
  - state=IDLE, select=0, enable=0, busy=0, done=0, sample=4'b0000, shadow=0, counter=0.
  - A partial scan is discarded and `sample` is not updated.
- All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - enable=0, select=0.
  - start=1 -> SETTLE, with select=0, enable=1, counter=DWELL-1.
- SETTLE:
  - counter!=0 -> decrement.
  - counter==0 -> SAMPLE.
  - SETTLE lasts exactly DWELL cycles per channel.
- SAMPLE:
  - shadow[select] <= mux_out.
  - select==3 -> DONE.
  - Otherwise select <= select+1, counter=DWELL-1 -> SETTLE.
  - select increments without wrap inside a scan.
- DONE:
  - sample <= shadow, including the bit captured in the final SAMPLE cycle.
  - done=1 for this single cycle; enable=0; select<=0 -> IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge 4*(DWELL+1). For DWELL=2 that is edge 12.
- start while busy is ignored; no queuing.
- start held high continuously: a new scan begins in the IDLE cycle after DONE, so back-to-back scans have a 1-cycle IDLE gap.
- mux_out is sampled only in SAMPLE; changes at other times have no effect.
- sample holds its value between scans.
- DWELL=1 is legal: one SETTLE cycle per channel.
- DWELL=0 is illegal; the implementation flags it with an elaboration-time check.

Optional Feature:
- SCAN_CONTINUOUS_EN defined:
  - DONE goes directly to SETTLE (select=0, enable stays 1, counter=DWELL-1) if start==1; otherwise to IDLE.
  - There is no IDLE gap; done pulses once every 4*(DWELL+1)+1 cycles.
- Undefined: behaviour exactly as above (DONE always returns to IDLE).

Decomposition:
- Shared package mux_scan_pkg holds:
  - the state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the channel count constant NUM_CH=4;
  - the last-channel index constant LAST_CH=2'd3.
- One sub-module, scan_dwell_counter:
  - loadable down-counter, CNT_W wide;
  - inputs clk, reset, load, load_val, dec; output zero.
- Top level holds the FSM, select/shadow/sample registers and output logic.

Test Plan:
- Reset mid-scan:
  - Start a scan; assert reset during channel 2 SETTLE.
  - Next cycle: select=0, enable=0, busy=0, done=0, sample unchanged at 0.
- Basic scan, DWELL=2:
  - mux model with a=1, b=0, c=1, d=1; pulse start.
  - Required: select sequence 0,1,2,3 (each held 3 cycles); enable=1 throughout.
  - done high exactly at edge 12; sample=4'b1101.
- Start ignored while busy:
  - Re-pulse start during the channel-1 SETTLE.
  - Exactly one done pulse; timing unchanged.
- Held start, macro off:
  - Hold start=1, DWELL=1.
  - done pulses at edges 8 and 18 (one IDLE cycle between scans).
- Held start, SCAN_CONTINUOUS_EN on:
  - Hold start=1, DWELL=1.
  - done at edges 8 and 17; enable never drops between scans.
- Sample timing:
  - Toggle mux_out during SETTLE but hold it stable in SAMPLE with pattern 0,1,0,1 per channel.
  - sample=4'b1010; SETTLE-cycle glitches are not captured.
